regfile_write_port: RTL

//  Write side of the 32-entry register file. Owns the register storage and

---
 rtl/regfile_write_port.sv | 111 +++++++++++
 1 files changed

// File: rtl/regfile_write_port.sv
// Register file write side: 32 x DATA_W storage, byte-enabled writes, per-register written flags, sequential clear engine.
// Latency: an accepted write is visible on regsout one cycle later; a clear takes 32 cycles.
// Backpressure: wrready drops for the 32 clear cycles; a write offered then is not taken and must be held.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   wrvalid/wrready   write handshake; awr/din/byteen are the write address, data and byte enables
//   clrreq            start a whole-file clear (honoured only when idle)
//   busy              clear engine running
//   regsout           flat bus, register i on bits [DATA_W*i +: DATA_W]
//   written           bit i set once register i has taken any byte since the last reset/clear
module regfile_write_port #(
    parameter int DATA_W  = 32,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wrvalid,
    output logic                   wrready,
    input  logic [4:0]             awr,
    input  logic [DATA_W-1:0]      din,
    input  logic [DATA_W/8-1:0]    byteen,
    input  logic                   clrreq,
    output logic                   busy,
    output logic [32*DATA_W-1:0]   regsout,
    output logic [31:0]            written
);

    localparam int NBYTES = DATA_W / 8;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [0:0] state;
    logic [4:0] cnt;
    logic       wr_acc;

    // wrready is a flop that mirrors state==IDLE, so acceptance needs no extra decode.
    assign wr_acc = wrvalid && wrready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= 5'd0;
            wrready <= 1'b1;
            busy    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clrreq) begin
                        state   <= ST_CLEAR;
                        cnt     <= 5'd0;
                        wrready <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                default: begin
                    // Counter wraps 31 -> 0 exactly on the exit edge.
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state   <= ST_IDLE;
                        wrready <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
            endcase
        end
    end

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_val,
        input logic [DATA_W-1:0] new_val,
        input logic [NBYTES-1:0] be
    );
        logic [DATA_W-1:0] res;
        res = old_val;
        for (int k = 0; k < NBYTES; k++) begin
            if (be[k]) res[8*k +: 8] = new_val[8*k +: 8];
        end
        return res;
    endfunction

    for (genvar i = 0; i < 32; i++) begin : g_reg
        logic [DATA_W-1:0] q;
        logic              w;
        logic              wr_hit;
        logic              clr_hit;

        // Writes to r0 are accepted but dropped when r0 is hardwired.
        assign wr_hit  = wr_acc && (awr == 5'(i)) && !(ZERO_R0 && (i == 0));
        // Writes and clears are mutually exclusive (writes only in IDLE).
        assign clr_hit = (state == ST_CLEAR) && (cnt == 5'(i));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q <= '0;
                w <= 1'b0;
            end else if (clr_hit) begin
                q <= '0;
                w <= 1'b0;
            end else if (wr_hit) begin
                q <= merge_bytes(q, din, byteen);
                if (|byteen) w <= 1'b1;
            end
        end

        assign regsout[DATA_W*i +: DATA_W] = q;
        assign written[i]                  = w;
    end

endmodule
